// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice: bubble instruction,
// reset PC default, FSM encoding and the {pc,insn} prefetch entry.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of {pc,insn} entries; clear overrides push and pop.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head_data,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; only read while the FIFO is non-empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok_s && !clear && !rst) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the decoder's ir/pc1/flush interface.
// Optional FETCH_PERF_EN adds saturating bubble/redirect event counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ir,
  output logic [31:0] pc1,
  output logic        flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_r;
  fetch_state_e  state_nxt_s;
  logic [31:0]   fpc_r;
  logic [31:0]   ir_r;
  logic [31:0]   pc1_r;
  logic [31:0]   tgt_s;
  logic          req_s;
  logic          push_s;
  logic          pop_s;
  logic          outstanding_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;
  fetch_entry_t  head_s;
  fetch_entry_t  push_data_s;

  assign flush         = redirect;
  assign imem_req      = req_s;
  assign imem_addr     = fpc_r;
  assign ir            = ir_r;
  assign pc1           = pc1_r;
  assign tgt_s         = word_align(redirect_pc);
  assign outstanding_s = (state_r != S_REQ);
  assign push_s        = (state_r == S_WAIT) && imem_valid && !redirect;
  assign pop_s         = !redirect && !stall && !empty_s;
  assign push_data_s   = '{pc: fpc_r, insn: imem_rdata};

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head_data (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Request decode and next state; a response in flight during a redirect
  // is either consumed now (valid) or swallowed later in S_DROP.
  always_comb begin
    state_nxt_s = state_r;
    req_s       = 1'b0;
    case (state_r)
      S_REQ: begin
        if (!rst && !redirect && !full_s &&
            (int'(count_s) + int'(outstanding_s) < DEPTH)) begin
          req_s       = 1'b1;
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_valid) begin
          state_nxt_s = S_REQ;
        end else if (redirect) begin
          state_nxt_s = S_DROP;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_DROP: begin
        if (imem_valid) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_DROP;
        end
      end
      default: state_nxt_s = S_REQ;
    endcase
  end

  // FSM state, fetch PC and the decoder-facing output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_REQ;
      fpc_r   <= RESET_PC;
      ir_r    <= NOP_INSN;
      pc1_r   <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      if (redirect) begin
        fpc_r <= tgt_s;
        ir_r  <= NOP_INSN;
        pc1_r <= tgt_s;
      end else begin
        if (push_s) fpc_r <= fpc_r + 32'd4;
        if (pop_s) begin
          ir_r  <= head_s.insn;
          pc1_r <= head_s.pc;
        end else if (!stall) begin
          ir_r <= NOP_INSN;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] bub_cnt_r;
  logic [31:0] rdr_cnt_r;

  assign perf_bubble_cnt   = bub_cnt_r;
  assign perf_redirect_cnt = rdr_cnt_r;

  // Saturating event counters for empty-buffer bubbles and redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      bub_cnt_r <= 32'd0;
      rdr_cnt_r <= 32'd0;
    end else begin
      if (!redirect && !stall && empty_s && (bub_cnt_r != 32'hFFFF_FFFF))
        bub_cnt_r <= bub_cnt_r + 32'd1;
      if (redirect && (rdr_cnt_r != 32'hFFFF_FFFF))
        rdr_cnt_r <= rdr_cnt_r + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based reference model checked every
// cycle, plus hand-computed expectations at key cycles of each scenario.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_valid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, flush;
  logic [31:0] imem_addr, ir, pc1;
  logic        hi_req, hi_valid, hi_flush;
  logic [31:0] hi_addr, hi_rdata, hi_ir, hi_pc1;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_redirect_cnt, hi_pb, hi_pr;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .ir(ir), .pc1(pc1),
    .flush(flush)
`ifdef FETCH_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH), .NOP_INSN(NOP)) dut_hi (
    .clk(clk), .rst(rst), .imem_req(hi_req), .imem_addr(hi_addr),
    .imem_rdata(hi_rdata), .imem_valid(hi_valid), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(32'h0000_0000), .ir(hi_ir), .pc1(hi_pc1),
    .flush(hi_flush)
`ifdef FETCH_PERF_EN
    , .perf_bubble_cnt(hi_pb), .perf_redirect_cnt(hi_pr)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;
  int resp_due = -1;
  int hi_due = -1;
  logic [31:0] resp_data, hi_data;
  logic [31:0] hi_log[$];

  // reference model state
  logic [63:0] m_buf[$];
  logic [31:0] m_fpc, m_ir, m_pc1, m_bub, m_rdc;
  int          m_pend = 0;   // 0 idle, 1 word to keep in flight, 2 word to discard in flight
  logic        m_known = 1'b0;
  logic        exp_req, exp_flush;
  logic [31:0] exp_addr, exp_ir, exp_pc1, exp_bub, exp_rdc;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_outputs();
    exp_flush = redirect;
    exp_req   = !rst && m_known && (m_pend == 0) && !redirect && (m_buf.size() < DEPTH);
    exp_addr  = m_fpc;
    exp_ir    = m_ir;
    exp_pc1   = m_pc1;
    exp_bub   = m_bub;
    exp_rdc   = m_rdc;
  endfunction

  function automatic void model_advance();
    logic [63:0] e;
    logic [31:0] t;
    if (rst) begin
      m_buf.delete();
      m_fpc = RPC; m_pend = 0; m_ir = NOP; m_pc1 = RPC;
      m_bub = 32'd0; m_rdc = 32'd0; m_known = 1'b1;
    end else if (redirect) begin
      t = {redirect_pc[31:2], 2'b00};
      m_buf.delete();
      m_ir = NOP; m_pc1 = t; m_fpc = t;
      if (m_pend == 1) m_pend = imem_valid ? 0 : 2;
      else if (m_pend == 2 && imem_valid) m_pend = 0;
      if (m_rdc != 32'hFFFF_FFFF) m_rdc = m_rdc + 32'd1;
    end else begin
      if (!stall) begin
        if (m_buf.size() > 0) begin
          e = m_buf.pop_front();
          m_ir = e[31:0]; m_pc1 = e[63:32];
        end else begin
          m_ir = NOP;
          if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 32'd1;
        end
      end
      if (imem_valid && m_pend == 1) begin
        m_buf.push_back({m_fpc, imem_rdata});
        m_fpc = m_fpc + 32'd4;
        m_pend = 0;
      end else if (imem_valid && m_pend == 2) begin
        m_pend = 0;
      end
      if (exp_req) m_pend = 1;
    end
  endfunction

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (m_known) begin
      chk("flush", {31'd0, flush}, {31'd0, exp_flush});
      chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      chk("imem_addr", imem_addr, exp_addr);
      chk("ir", ir, exp_ir);
      chk("pc1", pc1, exp_pc1);
`ifdef FETCH_PERF_EN
      chk("perf_bubble", perf_bubble_cnt, exp_bub);
      chk("perf_redirect", perf_redirect_cnt, exp_rdc);
`endif
    end
  end

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc);
    stall = st; redirect = rd; redirect_pc = rpc;
  endtask

  task automatic half1();
    model_outputs();
    @(negedge clk); #1;
  endtask

  task automatic half2();
    if (imem_req) begin resp_due = cyc + lat; resp_data = word_at(imem_addr); end
    if (hi_req) begin
      hi_due = cyc + 1; hi_data = word_at(hi_addr);
      if (hi_log.size() < 3) hi_log.push_back(hi_addr);
    end
    model_advance();
    @(posedge clk); #1;
    cyc++;
    imem_valid = (resp_due == cyc);
    imem_rdata = imem_valid ? resp_data : 32'h0000_0000;
    hi_valid   = (hi_due == cyc);
    hi_rdata   = hi_valid ? hi_data : 32'h0000_0000;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive(1'b0, 1'b0, 32'h0);
    resp_due = -1; hi_due = -1; imem_valid = 1'b0; hi_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin half1(); half2(); end
    rst = 1'b0; cyc = 1;
  endtask

  logic [31:0] wrap_exp [3];

  initial begin
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;
    rst = 1'b1; drive(1'b0, 1'b0, 32'h0);
    imem_valid = 1'b0; imem_rdata = 32'h0; hi_valid = 1'b0; hi_rdata = 32'h0;
    @(posedge clk); #1;

    // Latency 1 streaming, then a 5-cycle stall from the cycle ir holds insn@0x4.
    lat = 1; do_reset();
    for (int c = 1; c <= 12; c++) begin
      drive((c >= 6 && c <= 10), 1'b0, 32'h0);
      half1();
      if (c == 1) begin
        chk("rst_ir", ir, NOP); chk("rst_pc1", pc1, 32'h0);
        chk("c1_req", {31'd0, imem_req}, 32'd1); chk("c1_addr", imem_addr, 32'h0);
      end
      if (c == 3) chk("c3_addr", imem_addr, 32'h4);
      if (c == 4) begin chk("c4_ir", ir, 32'hC0DE_0000); chk("c4_pc1", pc1, 32'h0); end
      if (c == 5) chk("c5_addr", imem_addr, 32'h8);
      if (c == 6) begin chk("c6_ir", ir, 32'hC0DE_0004); chk("c6_pc1", pc1, 32'h4); end
      if (c == 9) chk("full_noreq", {31'd0, imem_req}, 32'd0);
      if (c == 10) begin chk("stall_ir", ir, 32'hC0DE_0004); chk("stall_pc1", pc1, 32'h4); end
      if (c == 12) begin chk("c12_ir", ir, 32'hC0DE_0008); chk("c12_pc1", pc1, 32'h8); end
      half2();
    end
    chk("wrap_n", hi_log.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("wrap_addr", (i < hi_log.size()) ? hi_log[i] : 32'hXXXX_XXXX, wrap_exp[i]);

    // Redirect while waiting (latency 3): stale response dropped.
    lat = 3; do_reset();
    for (int c = 1; c <= 10; c++) begin
      drive(1'b0, (c == 2), (c == 2) ? 32'h0000_0103 : 32'h0);
      half1();
      if (c == 2) chk("rw_flush", {31'd0, flush}, 32'd1);
      if (c == 3) begin
        chk("rw_ir", ir, NOP); chk("rw_pc1", pc1, 32'h100);
        chk("rw_drop_noreq", {31'd0, imem_req}, 32'd0);
      end
      if (c == 5) begin chk("rw_req", {31'd0, imem_req}, 32'd1); chk("rw_addr", imem_addr, 32'h100); end
      if (c == 10) begin chk("rw_ir2", ir, 32'hC0DE_0100); chk("rw_pc1b", pc1, 32'h100); end
      half2();
    end

    // Redirect coincident with imem_valid (latency 1): no drop state.
    lat = 1; do_reset();
    for (int c = 1; c <= 6; c++) begin
      drive(1'b0, (c == 2), (c == 2) ? 32'h0000_0200 : 32'h0);
      half1();
      if (c == 3) begin
        chk("rv_req", {31'd0, imem_req}, 32'd1); chk("rv_addr", imem_addr, 32'h200);
        chk("rv_pc1", pc1, 32'h200);
      end
      if (c == 4) chk("rv_ir_nop", ir, NOP);
      if (c == 6) begin chk("rv_ir", ir, 32'hC0DE_0200); chk("rv_pc1b", pc1, 32'h200); end
      half2();
    end

    // Back-to-back redirects: the last target wins.
    lat = 3; do_reset();
    for (int c = 1; c <= 5; c++) begin
      drive(1'b0, (c == 2 || c == 3), (c == 2) ? 32'h104 : ((c == 3) ? 32'h208 : 32'h0));
      half1();
      if (c == 4) chk("bb_pc1", pc1, 32'h208);
      if (c == 5) chk("bb_addr", imem_addr, 32'h208);
      half2();
    end

    // Bubble/redirect counting, then reset in the middle of a request.
    lat = 1; do_reset();
    for (int c = 1; c <= 7; c++) begin
      drive(1'b0, (c == 5 || c == 6), (c == 5) ? 32'h40 : ((c == 6) ? 32'h82 : 32'h0));
      half1();
      if (c == 7) begin
        chk("pf_addr", imem_addr, 32'h80); chk("pf_pc1", pc1, 32'h80);
`ifdef FETCH_PERF_EN
        chk("pf_bub3", perf_bubble_cnt, 32'd3); chk("pf_rdc2", perf_redirect_cnt, 32'd2);
`endif
      end
      half2();
    end
    do_reset();
    drive(1'b0, 1'b0, 32'h0);
    half1();
    chk("mr_addr", imem_addr, RPC);
    chk("mr_ir", ir, NOP);
`ifdef FETCH_PERF_EN
    chk("mr_bub0", perf_bubble_cnt, 32'd0); chk("mr_rdc0", perf_redirect_cnt, 32'd0);
`endif
    half2();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
